// File: rtl/weight_fifo.sv
// weight_fifo: row-wide circular buffer that feeds weight rows to the array.
// Rows are written whole, popped in order with a one-cycle registered read,
// and every ARRAY_DIM popped rows are marked with a tile_done_o pulse.
//
// Handshake: wr_en_i is a request that is taken only while full_o is low and
// is otherwise dropped (flagging overflow_o). load_weights_i pops only while
// empty_o is low. weight_fifo_valid_output qualifies rd_data_o for exactly the
// cycle after the pop; there is no backpressure on the read side.
module weight_fifo #(
    parameter int WEIGHT_W  = 8,
    parameter int ARRAY_DIM = 32,
    parameter int DEPTH     = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_en_i,
    input  logic [ARRAY_DIM*WEIGHT_W-1:0] wr_data_i,
    output logic                          full_o,
    input  logic                          load_weights_i,
    output logic [ARRAY_DIM*WEIGHT_W-1:0] rd_data_o,
    output logic                          weight_fifo_valid_output,
    output logic                          empty_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic                          tile_rdy_o,
    output logic                          tile_done_o,
    output logic                          overflow_o
);

    localparam int ROW_W  = ARRAY_DIM * WEIGHT_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TILE_W = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;

    logic [ROW_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [ROW_W-1:0]  rd_data_q;
    logic              valid_q;
    logic              overflow_q;
    logic [TILE_W-1:0] tile_cnt_q;

    logic wr_accept;
    logic pop;
    logic last_row;

    // Status flags come from the registered count only, so a pop in the same
    // cycle never frees room for a write while full.
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign tile_rdy_o = (count_q >= CNT_W'(ARRAY_DIM));
    assign count_o    = count_q;

    assign wr_accept = wr_en_i && !full_o;
    assign pop       = load_weights_i && !empty_o;

    assign rd_data_o                = rd_data_q;
    assign weight_fifo_valid_output = valid_q;
    assign overflow_o               = overflow_q;

    assign last_row    = (tile_cnt_q == TILE_W'(ARRAY_DIM - 1));
    assign tile_done_o = valid_q && last_row;

    // Row storage: written on accepted writes, never reset.
    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is 2^n.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({wr_accept, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Registered read port: capture the head row on a pop, otherwise hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= pop;
            if (pop) begin
                rd_data_q <= mem[rd_ptr_q];
            end
        end
    end

    // Sticky record of any dropped write; only reset clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else if (wr_en_i && full_o) begin
            overflow_q <= 1'b1;
        end
    end

    // Tile row counter advances once per output row and wraps after the last.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tile_cnt_q <= '0;
        end else if (valid_q) begin
            tile_cnt_q <= last_row ? '0 : tile_cnt_q + TILE_W'(1);
        end
    end

endmodule

// File: tb/tb_weight_fifo.sv
// Directed bench for weight_fifo with default parameters (8 x 32 weights,
// 64 rows). A small occupancy/tile model plus an expected-row queue tracks
// what each cycle must show; scenario totals are hand-computed constants.
module tb_weight_fifo;

    localparam int WEIGHT_W  = 8;
    localparam int ARRAY_DIM = 32;
    localparam int DEPTH     = 64;
    localparam int ROW_W     = ARRAY_DIM * WEIGHT_W;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic                   wr_en;
    logic [ROW_W-1:0]       wr_data;
    logic                   full;
    logic                   load;
    logic [ROW_W-1:0]       rd_data;
    logic                   valid;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic                   tile_rdy;
    logic                   tile_done;
    logic                   overflow;

    weight_fifo #(
        .WEIGHT_W (WEIGHT_W),
        .ARRAY_DIM(ARRAY_DIM),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .wr_en_i                 (wr_en),
        .wr_data_i               (wr_data),
        .full_o                  (full),
        .load_weights_i          (load),
        .rd_data_o               (rd_data),
        .weight_fifo_valid_output(valid),
        .empty_o                 (empty),
        .count_o                 (count),
        .tile_rdy_o              (tile_rdy),
        .tile_done_o             (tile_done),
        .overflow_o              (overflow)
    );

    // ---------------- scoreboard / model ----------------
    logic [ROW_W-1:0] exp_q[$];
    logic [ROW_W-1:0] m_row;
    int               m_cnt;
    int               m_tile;
    logic             m_valid;
    logic             m_ovf;

    int n_checks;
    int n_pass;

    // per-scenario observations
    int n_valid;
    int n_done;
    int last_done_at;

    task automatic check(input string tag, input logic [ROW_W-1:0] got,
                         input logic [ROW_W-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] row_of(input int v);
        return {(ROW_W / 32){v}};
    endfunction

    task automatic clear_stats();
        n_valid      = 0;
        n_done       = 0;
        last_done_at = 0;
    endtask

    task automatic check_outputs();
        check("valid",     ROW_W'(valid),     ROW_W'(m_valid));
        check("rd_data",   rd_data,           m_row);
        check("count",     ROW_W'(count),     ROW_W'(m_cnt));
        check("full",      ROW_W'(full),      ROW_W'(m_cnt == DEPTH));
        check("empty",     ROW_W'(empty),     ROW_W'(m_cnt == 0));
        check("tile_rdy",  ROW_W'(tile_rdy),  ROW_W'(m_cnt >= ARRAY_DIM));
        check("tile_done", ROW_W'(tile_done), ROW_W'(m_valid && (m_tile == ARRAY_DIM - 1)));
        check("overflow",  ROW_W'(overflow),  ROW_W'(m_ovf));
    endtask

    // One clock: apply inputs, advance past the edge, update the model, compare.
    task automatic cycle(input logic wr, input logic [ROW_W-1:0] d, input logic ld);
        logic acc;
        logic pp;
        wr_en   = wr;
        wr_data = d;
        load    = ld;
        acc = wr && (m_cnt != DEPTH);
        pp  = ld && (m_cnt != 0);
        if (wr && !acc) m_ovf = 1'b1;
        @(posedge clk);
        #1;
        if (m_valid) m_tile = (m_tile == ARRAY_DIM - 1) ? 0 : m_tile + 1;
        m_valid = pp;
        if (pp) m_row = exp_q.pop_front();
        if (acc) exp_q.push_back(d);
        m_cnt = m_cnt + int'(acc) - int'(pp);
        check_outputs();
        if (valid) n_valid++;
        if (tile_done) begin
            n_done++;
            last_done_at = n_valid;
        end
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        load  = 1'b0;
        rst   = 1'b1;
        #1;
        exp_q.delete();
        m_row   = '0;
        m_cnt   = 0;
        m_tile  = 0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        // reset values must show without waiting for a clock edge
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int valid_cycle;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        load     = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Rows 0..31, with tile_rdy rising exactly as count reaches 32.
        for (int i = 0; i < 31; i++) cycle(1'b1, row_of(i), 1'b0);
        check("r029_cnt31", ROW_W'(count), ROW_W'(31));
        check("r029_rdy31", ROW_W'(tile_rdy), ROW_W'(0));
        cycle(1'b1, row_of(31), 1'b0);
        check("r029_rdy32", ROW_W'(tile_rdy), ROW_W'(1));
        clear_stats();
        cycle(1'b0, '0, 1'b1);
        check("r029_cnt_back", ROW_W'(count), ROW_W'(31));
        check("r029_rdy_fall", ROW_W'(tile_rdy), ROW_W'(0));
        for (int i = 0; i < 33; i++) cycle(1'b0, '0, 1'b1);
        check("r024_nvalid",  ROW_W'(n_valid), ROW_W'(32));
        check("r024_ndone",   ROW_W'(n_done), ROW_W'(1));
        check("r024_done_at", ROW_W'(last_done_at), ROW_W'(32));
        check("r024_count",   ROW_W'(count), ROW_W'(0));

        // Fill to 64, then one dropped write.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, row_of(100 + i), 1'b0);
        cycle(1'b1, row_of(999), 1'b0);
        check("r025_full",  ROW_W'(full), ROW_W'(1));
        check("r025_ovf",   ROW_W'(overflow), ROW_W'(1));
        check("r025_count", ROW_W'(count), ROW_W'(64));
        clear_stats();
        // Write and pop while full: the write is still dropped.
        cycle(1'b1, row_of(777), 1'b1);
        check("r013_count", ROW_W'(count), ROW_W'(63));
        for (int i = 0; i < 66; i++) cycle(1'b0, '0, 1'b1);
        check("r025_nvalid", ROW_W'(n_valid), ROW_W'(64));
        check("r025_empty",  ROW_W'(empty), ROW_W'(1));
        check("r025_ovf_sticky", ROW_W'(overflow), ROW_W'(1));

        // Steady state at 10 rows with simultaneous write and pop.
        for (int i = 0; i < 10; i++) cycle(1'b1, row_of(200 + i), 1'b0);
        clear_stats();
        for (int i = 0; i < 100; i++) cycle(1'b1, row_of(300 + i), 1'b1);
        check("r026_count", ROW_W'(count), ROW_W'(10));
        for (int i = 0; i < 11; i++) cycle(1'b0, '0, 1'b1);
        check("r026_nvalid", ROW_W'(n_valid), ROW_W'(110));
        check("r026_ndone",  ROW_W'(n_done), ROW_W'(3));

        // Pop requested on an empty buffer, single write in cycle 5.
        clear_stats();
        valid_cycle = -1;
        for (int k = 0; k < 11; k++) begin
            cycle(k == 5, row_of(500), 1'b1);
            if (valid && valid_cycle < 0) valid_cycle = k + 1;
        end
        check("r027_nvalid", ROW_W'(n_valid), ROW_W'(1));
        check("r027_cycle",  ROW_W'(valid_cycle), ROW_W'(7));

        // Reset in the middle of a tile.
        do_reset();
        for (int i = 0; i < 32; i++) cycle(1'b1, row_of(600 + i), 1'b0);
        clear_stats();
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1);
        check("r028_nvalid20", ROW_W'(n_valid), ROW_W'(20));
        do_reset();
        for (int i = 0; i < 32; i++) cycle(1'b1, row_of(700 + i), 1'b0);
        clear_stats();
        for (int i = 0; i < 34; i++) cycle(1'b0, '0, 1'b1);
        check("r028_ndone",   ROW_W'(n_done), ROW_W'(1));
        check("r028_done_at", ROW_W'(last_done_at), ROW_W'(32));
        check("r028_drain",   ROW_W'(exp_q.size()), ROW_W'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
